// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back L1 data cache.
// Holds the FSM state encodings, address-split widths and the tag-entry layout.
package dcache_pkg;

    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;
    localparam int WORD_W     = 32;
    // Widest tag any legal geometry can need (a single-line cache on a 32-bit address).
    localparam int TAG_MAX_W  = 32 - OFFSET_W;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;
    localparam logic [1:0] REFILL    = 2'd3;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag and line storage for the data cache: combinational read, synchronous write.
// Only valid/dirty are reset; tags and line data keep whatever they held.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES     = 16,
    parameter int LINE_BITS = 256,
    parameter int IDXW      = $clog2(LINES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDXW-1:0]      idx,
    output tag_entry_t           entry,
    output logic [LINE_BITS-1:0] line,
    input  logic                 we,
    input  tag_entry_t           wr_entry,
    input  logic [LINE_BITS-1:0] wr_line
);

    logic [LINES-1:0]     valid;
    logic [LINES-1:0]     dirty;
    logic [TAG_MAX_W-1:0] tags  [LINES];
    logic [LINE_BITS-1:0] lines [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (we) begin
            valid[idx] <= wr_entry.valid;
            dirty[idx] <= wr_entry.dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[idx]  <= wr_entry.tag;
            lines[idx] <= wr_line;
        end
    end

    assign entry = '{valid: valid[idx], dirty: dirty[idx], tag: tags[idx]};
    assign line  = lines[idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete combinationally; misses stall the pipeline while whole lines move to/from memory.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int LINES     = 16,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_write_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int IDXW  = $clog2(LINES);
    localparam int TAGW  = ADDR_W - IDXW - OFFSET_W;
    localparam int WORDS = LINE_BITS / WORD_W;

    logic [1:0]            state;
    logic [TAGW-1:0]       cpu_tag;
    logic [IDXW-1:0]       idx;
    logic [WORD_SEL_W-1:0] word_sel;
    logic                  unused_addr_lsb;

    tag_entry_t            entry;
    tag_entry_t            wr_entry;
    logic [LINE_BITS-1:0]  line;
    logic [LINE_BITS-1:0]  wr_line;
    logic [WORDS-1:0][WORD_W-1:0] words;
    logic [WORDS-1:0][WORD_W-1:0] merged;
    logic [31:0]           data_q;
    logic [ADDR_W-1:0]     wb_addr;
    logic [ADDR_W-1:0]     fetch_addr;
    logic                  hit;
    logic                  fill;
    logic                  we;

    assign cpu_tag         = cpu_addr_i[ADDR_W-1 -: TAGW];
    assign idx             = cpu_addr_i[OFFSET_W +: IDXW];
    assign word_sel        = cpu_addr_i[2 +: WORD_SEL_W];
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    dcache_sram #(
        .LINES     (LINES),
        .LINE_BITS (LINE_BITS),
        .IDXW      (IDXW)
    ) u_sram (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .idx      (idx),
        .entry    (entry),
        .line     (line),
        .we       (we),
        .wr_entry (wr_entry),
        .wr_line  (wr_line)
    );

    assign words      = line;
    assign wb_addr    = {entry.tag[TAGW-1:0], idx, {OFFSET_W{1'b0}}};
    assign fetch_addr = {cpu_tag, idx, {OFFSET_W{1'b0}}};

    assign hit  = cpu_req_i && (state == IDLE) && entry.valid
                  && (entry.tag == TAG_MAX_W'(cpu_tag));
    // An ack only counts while our own fetch is actually outstanding.
    assign fill = (state == ALLOCATE) && mem_enable_o && mem_ack_i;
    assign we   = (hit && cpu_write_i) || fill;

    always_comb begin
        merged           = words;
        merged[word_sel] = cpu_data_i;
        wr_entry         = '{valid: 1'b1, dirty: 1'b1, tag: TAG_MAX_W'(cpu_tag)};
        wr_line          = merged;
        if (fill) begin
            wr_entry.dirty = 1'b0;
            wr_line        = mem_data_i;
        end
    end

    // Stall is gated by reset so an aborted miss releases the pipeline immediately.
    assign cpu_stall_o = rst_i && ((state != IDLE) || (cpu_req_i && !hit));
    assign cpu_data_o  = hit ? words[word_sel] : data_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q <= '0;
        end else if (hit) begin
            data_q <= words[word_sel];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_i && !hit) begin
                        mem_enable_o <= 1'b1;
                        if (entry.valid && entry.dirty) begin
                            state       <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= wb_addr;
                            mem_data_o  <= line;
                        end else begin
                            state       <= ALLOCATE;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= fetch_addr;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state        <= ALLOCATE;
                        mem_enable_o <= 1'b0;
                        mem_write_o  <= 1'b0;
                    end
                end
                ALLOCATE: begin
                    // After a write-back, enable drops for a cycle before the fetch starts.
                    if (!mem_enable_o) begin
                        mem_enable_o <= 1'b1;
                        mem_addr_o   <= fetch_addr;
                    end else if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        state        <= REFILL;
                    end
                end
                REFILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
